// File: rtl/acoustic_burst_gen.sv
// Multi-channel ultrasonic burst generator.
// Each burst drives N_CH square-wave carriers. Every channel starts after its
// own delay, latched at the first burst cycle, and then emits exactly
// BURST_CYCLES full carrier periods. Bursts repeat every PERIOD_CYCLES when
// free-running (mode 0), or fire once per trigger (mode 1). After a burst, a
// rest window keeps the transducer idle until the period counter saturates.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable          run permission
//   mode            0 = free-running, 1 = triggered
//   trigger         single-cycle burst request (mode 1)
//   ch_delay        per-channel start delay; channel k uses [k*DELAY_W +: DELAY_W]
//   sig             carrier drive, one bit per channel
//   busy            high whenever the generator is not idle
//   burst_start     one-cycle pulse in the first burst cycle
//   burst_done      one-cycle pulse after the last channel's final period
module acoustic_burst_gen #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned HALF_PERIOD   = 1250,
  parameter int unsigned BURST_CYCLES  = 80,
  parameter int unsigned PERIOD_CYCLES = 200000000,
  parameter int unsigned DELAY_W       = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    mode,
  input  logic                    trigger,
  input  logic [N_CH*DELAY_W-1:0] ch_delay,
  output logic [N_CH-1:0]         sig,
  output logic                    busy,
  output logic                    burst_start,
  output logic                    burst_done
);

  localparam int unsigned CW = $clog2(2 * HALF_PERIOD);
  localparam int unsigned PW = $clog2(BURST_CYCLES + 1);
  localparam int unsigned TW = $clog2(PERIOD_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    REST = 2'd2
  } state_t;

  state_t            state;
  logic              mode_q;
  logic [TW-1:0]     per_cnt;
  logic              per_sat;

  // Per-channel counters: carrier phase, emitted periods, remaining delay.
  logic [CW-1:0]      car_cnt [N_CH];
  logic [PW-1:0]      prd_cnt [N_CH];
  logic [DELAY_W-1:0] dly_cnt [N_CH];
  logic [N_CH-1:0]    run;
  logic [N_CH-1:0]    fin;

  logic [CW-1:0]      car_nxt [N_CH];
  logic [PW-1:0]      prd_nxt [N_CH];
  logic [DELAY_W-1:0] dly_nxt [N_CH];
  logic [N_CH-1:0]    run_nxt;
  logic [N_CH-1:0]    fin_nxt;
  logic [N_CH-1:0]    sig_nxt;

  logic              go_c;

  assign per_sat = (per_cnt == TW'(PERIOD_CYCLES - 1));

  // Per-channel carrier sequencing: delay countdown, then full periods only.
  always_comb begin
    car_nxt = car_cnt;
    prd_nxt = prd_cnt;
    dly_nxt = dly_cnt;
    run_nxt = run;
    fin_nxt = fin;
    sig_nxt = sig;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (fin[k]) begin
        sig_nxt[k] = 1'b0;
      end else if (!run[k]) begin
        if (dly_cnt[k] == '0) begin
          run_nxt[k] = 1'b1;
          car_nxt[k] = '0;
          prd_nxt[k] = '0;
          sig_nxt[k] = 1'b1;
        end else begin
          dly_nxt[k] = dly_cnt[k] - DELAY_W'(1);
        end
      end else if (car_cnt[k] == CW'(2 * HALF_PERIOD - 1)) begin
        if (prd_cnt[k] == PW'(BURST_CYCLES - 1)) begin
          run_nxt[k] = 1'b0;
          fin_nxt[k] = 1'b1;
          sig_nxt[k] = 1'b0;
        end else begin
          prd_nxt[k] = prd_cnt[k] + PW'(1);
          car_nxt[k] = '0;
          sig_nxt[k] = 1'b1;
        end
      end else begin
        car_nxt[k] = car_cnt[k] + CW'(1);
        sig_nxt[k] = (car_cnt[k] < CW'(HALF_PERIOD - 1));
      end
    end
  end

  // Burst launch: from IDLE on request, back-to-back after a stretched
  // free-running burst, or from REST once the period has elapsed.
  always_comb begin
    go_c = 1'b0;
    case (state)
      IDLE:    go_c = enable && (!mode || trigger);
      FIRE:    go_c = (&fin) && enable && !mode_q && per_sat;
      REST:    go_c = enable && !mode && per_sat;
      default: go_c = 1'b0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= 1'b0;
      per_cnt     <= '0;
      sig         <= '0;
      busy        <= 1'b0;
      burst_start <= 1'b0;
      burst_done  <= 1'b0;
      run         <= '0;
      fin         <= '0;
      for (int k = 0; k < int'(N_CH); k++) begin
        car_cnt[k] <= '0;
        prd_cnt[k] <= '0;
        dly_cnt[k] <= '0;
      end
    end else begin
      burst_start <= go_c;
      burst_done  <= (state == FIRE) && !(&fin) && (&fin_nxt);
      if (!per_sat) begin
        per_cnt <= per_cnt + TW'(1);
      end
      if (go_c) begin
        state   <= FIRE;
        busy    <= 1'b1;
        mode_q  <= mode;
        per_cnt <= '0;
        sig     <= '0;
        run     <= '0;
        fin     <= '0;
        for (int k = 0; k < int'(N_CH); k++) begin
          dly_cnt[k] <= ch_delay[k*DELAY_W +: DELAY_W];
          car_cnt[k] <= '0;
          prd_cnt[k] <= '0;
        end
      end else begin
        case (state)
          FIRE: begin
            sig     <= sig_nxt;
            run     <= run_nxt;
            fin     <= fin_nxt;
            car_cnt <= car_nxt;
            prd_cnt <= prd_nxt;
            dly_cnt <= dly_nxt;
            // A burst always runs to completion; enable only picks the exit.
            if (&fin) begin
              if (enable) begin
                state <= REST;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          REST: begin
            if (!enable || (mode && per_sat)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acoustic_burst_gen.sv
// Bench for acoustic_burst_gen: two instances (period 100 and 20) share one
// stimulus; a timestamp-based model predicts every output on every cycle, and
// directed scenarios pin key event times with hand-computed values.
module tb_acoustic_burst_gen;

  localparam int HP = 4;
  localparam int BC = 3;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       mode;
  logic       trigger;
  logic [7:0] ch_delay;
  logic [1:0] sig0, sig1;
  logic       busy0, busy1, bs0, bs1, bd0, bd1;

  acoustic_burst_gen #(
    .N_CH(2), .HALF_PERIOD(HP), .BURST_CYCLES(BC), .PERIOD_CYCLES(100), .DELAY_W(4)
  ) u0 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .trigger(trigger),
    .ch_delay(ch_delay), .sig(sig0), .busy(busy0), .burst_start(bs0), .burst_done(bd0)
  );

  acoustic_burst_gen #(
    .N_CH(2), .HALF_PERIOD(HP), .BURST_CYCLES(BC), .PERIOD_CYCLES(20), .DELAY_W(4)
  ) u1 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .trigger(trigger),
    .ch_delay(ch_delay), .sig(sig1), .busy(busy1), .burst_start(bs1), .burst_done(bd1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: a burst is described by its start time and latched delays only.
  int   per_m [2] = '{100, 20};
  bit   act_m [2];
  int   rel_m [2];
  int   dl_m  [2][2];
  bit   mq_m  [2];
  logic [4:0] exp_m [2];

  function automatic int burst_len(input int d0, input int d1);
    return ((d0 > d1) ? d0 : d1) + 2 * HP * BC + 1;
  endfunction

  function automatic bit carrier(input int rel, input int d);
    int x;
    x = rel - d - 1;
    return (x >= 0) && (x < 2 * HP * BC) && ((x % (2 * HP)) < HP);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit st;
      int len;
      st = 1'b0;
      len = burst_len(dl_m[i][0], dl_m[i][1]);
      if (rst) begin
        act_m[i] = 1'b0;
      end else if (!act_m[i]) begin
        st = enable && (!mode || trigger);
      end else if (rel_m[i] < len) begin
        rel_m[i]++;
      end else if (rel_m[i] == len) begin
        if (!enable) act_m[i] = 1'b0;
        else if (!mq_m[i] && rel_m[i] >= per_m[i] - 1) st = 1'b1;
        else rel_m[i]++;
      end else begin
        if (!enable) act_m[i] = 1'b0;
        else if (rel_m[i] >= per_m[i] - 1) begin
          if (!mode) st = 1'b1;
          else act_m[i] = 1'b0;
        end else rel_m[i]++;
      end
      if (st) begin
        act_m[i]    = 1'b1;
        rel_m[i]    = 0;
        dl_m[i][0]  = int'(ch_delay[3:0]);
        dl_m[i][1]  = int'(ch_delay[7:4]);
        mq_m[i]     = mode;
      end
      len = burst_len(dl_m[i][0], dl_m[i][1]);
      if (act_m[i]) begin
        exp_m[i] = {carrier(rel_m[i], dl_m[i][1]), carrier(rel_m[i], dl_m[i][0]),
                    1'b1, rel_m[i] == 0, rel_m[i] == len};
      end else begin
        exp_m[i] = 5'b0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [4:0] got [2];
      got[0] = {sig0, busy0, bs0, bd0};
      got[1] = {sig1, busy1, bs1, bd1};
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (got[i] !== exp_m[i]) begin
          n_bad++;
          $display("FAIL model_cmp inst%0d t=%0t {sig,busy,start,done} got %b expected %b",
                   i, $time, got[i], exp_m[i]);
        end
      end
    end
  end

  task automatic check(input string nm, input int got, input int exp_v);
    n_vec++;
    if (got != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_start(input string nm);
    int k;
    k = 0;
    tick();
    while (!bs0 && k < 20) begin
      tick();
      k++;
    end
    check(nm, int'(bs0), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int f_sig0, f_sig1, f_done, f_st0, f_st1, f_s02, hi0, hi1, n_st, f_nb0, f_nb1;
    rst = 1'b1; enable = 1'b0; mode = 1'b0; trigger = 1'b0; ch_delay = 8'h00;
    tick(); tick(); tick();
    chk_en = 1'b1;
    check("rst_sig0", int'(sig0), 0);
    check("rst_busy0", int'(busy0), 0);
    check("rst_pulses0", int'({bs0, bd0}), 0);
    check("rst_busy1", int'(busy1), 0);

    // Free-run, delays {0,5}; delays change to {15,0} at t0+3.
    rst = 1'b0; mode = 1'b0; ch_delay = {4'd5, 4'd0}; enable = 1'b1;
    wait_start("freerun_start");
    f_sig1 = -1; f_done = -1; f_st0 = -1; f_st1 = -1; f_s02 = -1; hi0 = 0;
    for (int rel = 1; rel <= 140; rel++) begin
      tick();
      if (rel == 3) ch_delay = {4'd0, 4'd15};
      if (sig0[1] && f_sig1 < 0) f_sig1 = rel;
      if (bd0 && f_done < 0) f_done = rel;
      if (bs0 && f_st0 < 0) f_st0 = rel;
      if (bs1 && f_st1 < 0) f_st1 = rel;
      if (f_st0 < 0 && sig0[0]) hi0++;
      if (f_st0 >= 0 && sig0[0] && f_s02 < 0) f_s02 = rel;
    end
    check("fr_sig1_first_high", f_sig1, 6);
    check("fr_done", f_done, 30);
    check("fr_next_start", f_st0, 100);
    check("stretch_next_start", f_st1, 31);
    check("fr_ch0_high_cycles", hi0, 12);
    check("new_delay_sig0_first_high", f_s02, 116);

    // Reset mid-burst, then restart.
    rst = 1'b1; enable = 1'b0;
    tick();
    rst = 1'b0; ch_delay = {4'd5, 4'd0}; mode = 1'b0; enable = 1'b1;
    wait_start("rst_scn_start");
    for (int rel = 1; rel <= 12; rel++) tick();
    rst = 1'b1; enable = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_mid_sig0", int'(sig0), 0);
    check("rst_mid_busy0", int'(busy0), 0);
    f_done = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (bd0) f_done++;
    end
    check("rst_mid_no_done", f_done, 0);
    enable = 1'b1;
    wait_start("rst_restart");
    f_sig0 = -1; f_sig1 = -1; f_done = -1;
    for (int rel = 1; rel <= 35; rel++) begin
      tick();
      if (sig0[0] && f_sig0 < 0) f_sig0 = rel;
      if (sig0[1] && f_sig1 < 0) f_sig1 = rel;
      if (bd0 && f_done < 0) f_done = rel;
    end
    check("restart_sig0_first", f_sig0, 1);
    check("restart_sig1_first", f_sig1, 6);
    check("restart_done", f_done, 30);

    // Triggered mode, second trigger during rest is ignored.
    rst = 1'b1; enable = 1'b0;
    tick();
    rst = 1'b0; enable = 1'b1; mode = 1'b1; trigger = 1'b0;
    tick(); tick(); tick();
    check("trig_idle_busy", int'(busy0), 0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("trig_start", int'(bs0), 1);
    n_st = 0; f_nb0 = -1; f_nb1 = -1;
    for (int rel = 1; rel <= 120; rel++) begin
      tick();
      trigger = (rel == 50);
      if (bs0) n_st++;
      if (!busy0 && f_nb0 < 0) f_nb0 = rel;
      if (!busy1 && f_nb1 < 0) f_nb1 = rel;
    end
    trigger = 1'b0;
    check("trig_busy_fall", f_nb0, 100);
    check("trig_no_second_start", n_st, 0);
    check("trig_short_period_busy_fall", f_nb1, 32);

    // enable dropped mid-burst: burst completes, then idle.
    rst = 1'b1; enable = 1'b0;
    tick();
    rst = 1'b0; mode = 1'b0; ch_delay = {4'd5, 4'd0}; enable = 1'b1;
    wait_start("en_drop_start");
    f_done = -1; n_st = 0; hi0 = 0; hi1 = 0; f_nb0 = -1;
    for (int rel = 1; rel <= 60; rel++) begin
      tick();
      if (rel == 10) enable = 1'b0;
      if (bd0 && f_done < 0) f_done = rel;
      if (bs0) n_st++;
      if (sig0[0]) hi0++;
      if (sig0[1]) hi1++;
      if (rel == 31) f_nb0 = int'(busy0);
    end
    check("en_drop_done", f_done, 30);
    check("en_drop_busy_t31", f_nb0, 0);
    check("en_drop_no_restart", n_st, 0);
    check("en_drop_ch0_high", hi0, 12);
    check("en_drop_ch1_high", hi1, 12);

    // Randomized traffic, checked by the model every cycle.
    enable = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst = ($urandom_range(299) == 0);
      if ($urandom_range(39) == 0) enable = ~enable;
      if ($urandom_range(99) == 0) mode = ~mode;
      trigger = ($urandom_range(24) == 0);
      if ($urandom_range(49) == 0) ch_delay = 8'($urandom);
    end
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/acoustic_burst_gen.md
ACOUSTIC_BURST_GEN -- requirements
Module: acoustic_burst_gen

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of transducer channels.
REQ-002 SHALL have parameter HALF_PERIOD, default 1250, carrier half-period in clk cycles (40 kHz at 100 MHz).
REQ-003 SHALL have parameter BURST_CYCLES, default 80, carrier periods per burst (2 ms).
REQ-004 SHALL have parameter PERIOD_CYCLES, default 200000000, clk cycles between burst starts (2 s).
REQ-005 SHALL have parameter DELAY_W, default 12, width of each per-channel start delay.
REQ-006 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: enable  in  1  run permission; mode  in  1  0=free-running, 1=triggered; trigger  in  1  single-cycle burst request (mode 1).
REQ-008 SHALL have port ch_delay  in  N_CH*DELAY_W  per-channel start delay in clk cycles; channel k uses bits [k*DELAY_W +: DELAY_W].
REQ-009 SHALL have outputs: sig  out  N_CH  carrier drive; busy  out  1  state!=IDLE; burst_start  out  1  pulse; burst_done  out  1  pulse.

Function
REQ-010 SHALL implement states IDLE, FIRE, REST; all outputs registered.
REQ-011 IDLE: sig=0; enable&&!mode, or enable&&mode&&trigger, SHALL enter FIRE next edge.
REQ-012 SHALL assert burst_start for exactly the first FIRE cycle (t0) and latch ch_delay at that edge; ch_delay changes after t0 ignored until next burst.
REQ-013 sig[k] SHALL be 0 through cycle t0+d_k, then high for HALF_PERIOD cycles, low for HALF_PERIOD cycles, repeated BURST_CYCLES times, then 0; first high cycle = t0+d_k+1.
REQ-014 Every emitted carrier period SHALL be complete; no truncated half-periods under any input except rst.
REQ-015 FIRE->REST SHALL occur when all channels have finished; burst_done SHALL pulse one cycle, in the cycle after the latest channel's final low half-period.
REQ-016 Period counter SHALL count from 0 at t0 and saturate at PERIOD_CYCLES-1; width $clog2(PERIOD_CYCLES).
REQ-017 REST, mode 0, enable high: next burst_start SHALL occur at t0+PERIOD_CYCLES.
REQ-018 If burst has not finished by t0+PERIOD_CYCLES (stretch), next burst_start SHALL occur the cycle after burst_done, mode 0 and enable high.
REQ-019 REST, mode 1: SHALL return to IDLE when period counter saturates (minimum transducer rest); trigger in FIRE/REST ignored, not queued.
REQ-020 enable low during FIRE: burst SHALL complete; then IDLE instead of REST. enable low during REST: IDLE next edge.
REQ-021 mode changes SHALL be sampled only in IDLE and REST.
REQ-022 Carrier and delay counters SHALL be per-channel, widths $clog2(2*HALF_PERIOD), $clog2(BURST_CYCLES+1), DELAY_W; no wrap beyond defined ranges.

Reset
REQ-023 rst SHALL, at the next clk edge, force IDLE, sig=0, busy=0, burst_start=0, burst_done=0, clear all counters and latched delays.
REQ-024 rst mid-FIRE SHALL abort the burst without burst_done; first burst after rst release obeys REQ-011.

Verification (N_CH=2, HALF_PERIOD=4, BURST_CYCLES=3, PERIOD_CYCLES=100, DELAY_W=4)
REQ-025 Free-run, delays {0,5}: sig[0] high t0+1..4, 9..12, 17..20; sig[1] high t0+6..9, 14..17, 22..25; burst_done t0+30; next burst_start t0+100.
REQ-026 Triggered, one trigger, second trigger at t0+50: single burst, busy falls at t0+100, no second burst_start.
REQ-027 enable dropped at t0+10: all 3 periods per channel still emitted, burst_done t0+30, busy=0 at t0+31, no further burst_start.
REQ-028 rst at t0+12: sig=0, busy=0 after next edge; no burst_done; restart gives t0 timing identical to REQ-025.
REQ-029 ch_delay changed from {0,5} to {15,0} at t0+3: current burst per REQ-025; next burst uses {15,0}, sig[0] first high t0'+16.
REQ-030 PERIOD_CYCLES=20, delays {0,5}: burst_done t0+30, next burst_start t0+31.
